vga_bar_sequencer: RTL

//   Sequences the animated bar in the VGA character overlay: owns the bar fill level and

---
 rtl/vga_bar_sequencer.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/vga_bar_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : vga_bar_sequencer
// Purpose  : Owns the fill level of the animated overlay bar and drives the
//            thermometer pattern read by the pixel datapath. Animation step
//            requests come from a clk prescaler, but they are only applied at
//            frame_start (vertical blanking). A frame therefore never shows a
//            partly updated pattern.
// Ports    : clk          - system clock
//            rst_n        - asynchronous active-low reset
//            frame_start  - 1-cycle pulse at the start of vertical blanking
//            enable       - run animation (0 drops to IDLE at next frame_start)
//            mode         - 0 = fill-and-wrap, 1 = bounce (fill/hold/drain)
//            bar_pattern  - bit i set iff i < level (registered)
//            level        - current fill level 0..BAR_W (registered)
//            busy         - sequencer is not IDLE
//            wrap_pulse   - 1-cycle pulse when level returns to 0 from a cycle
// Revision : 1.0 - initial release
// ============================================================================
module vga_bar_sequencer #(
   parameter int BAR_W       = 112,
   parameter int TICK_DIV    = 10000000,
   parameter int HOLD_FRAMES = 60
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       frame_start,
   input  logic                       enable,
   input  logic                       mode,
   output logic [BAR_W-1:0]           bar_pattern,
   output logic [$clog2(BAR_W+1)-1:0] level,
   output logic                       busy,
   output logic                       wrap_pulse
);

   localparam int LW = $clog2(BAR_W + 1);
   localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam int HW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

   localparam logic [1:0] c_st_idle  = 2'd0;
   localparam logic [1:0] c_st_fill  = 2'd1;
   localparam logic [1:0] c_st_hold  = 2'd2;
   localparam logic [1:0] c_st_drain = 2'd3;

   localparam logic [LW-1:0] c_level_max  = LW'(BAR_W);
   localparam logic [LW-1:0] c_level_pre  = LW'(BAR_W - 1);
   localparam logic [PW-1:0] c_presc_last = PW'(TICK_DIV - 1);
   localparam logic [HW-1:0] c_hold_last  = HW'(HOLD_FRAMES - 1);

   logic [1:0]       r_state;
   logic [1:0]       w_state_next;
   logic [LW-1:0]    r_level;
   logic [LW-1:0]    w_level_next;
   logic [BAR_W-1:0] r_pattern;
   logic [BAR_W-1:0] w_pattern_next;
   logic             r_wrap;
   logic             w_wrap_next;
   logic [HW-1:0]    r_hold_cnt;
   logic [HW-1:0]    w_hold_next;
   logic [PW-1:0]    r_presc;
   logic             r_step_pend;
   logic             w_tick;
   logic             w_step;
   logic             w_busy;

   // Prescaler only runs outside IDLE, so a tick can never occur in IDLE.
   assign w_tick = (r_state != c_st_idle) && (r_presc == c_presc_last);
   // A tick coinciding with frame_start counts as pending for that frame.
   assign w_step = frame_start && (r_step_pend || w_tick);

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= c_st_idle;
      end else begin
         r_state <= w_state_next;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state / next-level logic. Everything changes only at frame_start,
   // which also gives the "frozen until next frame_start" behaviour when
   // enable drops mid-frame.
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_next = r_state;
      w_level_next = r_level;
      w_hold_next  = r_hold_cnt;
      w_wrap_next  = 1'b0;
      if (frame_start) begin
         if (!enable) begin
            w_state_next = c_st_idle;
            w_level_next = '0;
            w_hold_next  = '0;
         end else begin
            case (r_state)
               c_st_idle: begin
                  // Entering FILL consumes this frame_start, no step yet.
                  w_state_next = c_st_fill;
               end
               c_st_fill: begin
                  if (w_step) begin
                     if (r_level >= c_level_max) begin
                        w_level_next = '0;
                        w_wrap_next  = 1'b1;
                     end else begin
                        w_level_next = r_level + LW'(1);
                        // mode is only looked at on the step that fills the bar.
                        if ((r_level == c_level_pre) && mode) begin
                           w_state_next = c_st_hold;
                           w_hold_next  = '0;
                        end
                     end
                  end
               end
               c_st_hold: begin
                  if (r_hold_cnt == c_hold_last) begin
                     w_state_next = c_st_drain;
                     w_hold_next  = '0;
                  end else begin
                     w_hold_next = r_hold_cnt + HW'(1);
                  end
               end
               c_st_drain: begin
                  if (w_step) begin
                     if (r_level <= LW'(1)) begin
                        w_level_next = '0;
                        w_wrap_next  = (r_level == LW'(1));
                        w_state_next = c_st_fill;
                     end else begin
                        w_level_next = r_level - LW'(1);
                     end
                  end
               end
               default: begin
                  w_state_next = c_st_idle;
                  w_level_next = '0;
               end
            endcase
         end
      end
   end

   // ------------------------------------------------------------------------
   // Output decode
   // ------------------------------------------------------------------------
   always_comb begin
      w_busy = (r_state != c_st_idle);
   end

   // Thermometer pattern is derived from the next level so that the
   // registered pattern and level always change on the same edge.
   genvar gi;
   generate
      for (gi = 0; gi < BAR_W; gi++) begin : g_pattern
         assign w_pattern_next[gi] = (w_level_next > LW'(gi));
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Datapath registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_level     <= '0;
         r_pattern   <= '0;
         r_wrap      <= 1'b0;
         r_hold_cnt  <= '0;
         r_presc     <= '0;
         r_step_pend <= 1'b0;
      end else begin
         r_level    <= w_level_next;
         r_pattern  <= w_pattern_next;
         r_wrap     <= w_wrap_next;
         r_hold_cnt <= w_hold_next;

         if ((r_state == c_st_idle) || (w_state_next == c_st_idle) || w_tick) begin
            r_presc <= '0;
         end else begin
            r_presc <= r_presc + PW'(1);
         end

         // Ticks in HOLD are ignored; frame_start always consumes the request.
         if (frame_start || (w_state_next == c_st_idle)) begin
            r_step_pend <= 1'b0;
         end else if (w_tick && ((r_state == c_st_fill) || (r_state == c_st_drain))) begin
            r_step_pend <= 1'b1;
         end
      end
   end

   assign level       = r_level;
   assign bar_pattern = r_pattern;
   assign wrap_pulse  = r_wrap;
   assign busy        = w_busy;

endmodule
`default_nettype wire
